// File: rtl/image_write.sv
// image_write: captures one WIDTH x HEIGHT RGB frame, then streams it out as a 24-bit BMP byte stream.
// Latency: first header byte 1 cycle after capture completes; 1 byte/cycle; byte_ready low stalls output with data held.
module image_write #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_last,
    output logic       frame_done
);
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int ROWB  = ((3 * WIDTH + 3) / 4) * 4;
    localparam int PAD   = ROWB - 3 * WIDTH;
    localparam int FSIZE = 54 + HEIGHT * ROWB;

    localparam logic [31:0]   C_FSIZE    = 32'(FSIZE);
    localparam logic [31:0]   C_W        = 32'(WIDTH);
    localparam logic [31:0]   C_H        = 32'(HEIGHT);
    localparam logic [1:0]    C_PAD_LAST = 2'((PAD > 0) ? PAD - 1 : 0);
    localparam logic [AW-1:0] C_PIX_LAST = AW'(NPIX - 1);
    localparam logic [CW-1:0] C_COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {S_FILL, S_HDR, S_BODY, S_DONE} state_t;

    state_t        r_state, w_nxt_state;
    logic          r_pix_rdy;
    logic [AW-1:0] r_pix_cnt;
    logic [23:0]   r_store [NPIX];
    logic [23:0]   r_rd_dat;

    logic [5:0]    r_hdr_idx, w_nxt_hdr;
    logic [RW-1:0] r_row, w_nxt_row;
    logic [CW-1:0] r_col, w_nxt_col;
    logic [1:0]    r_sub, w_nxt_sub;
    logic [1:0]    r_pad, w_nxt_pad;
    logic          r_in_pad, w_nxt_in_pad;
    logic          r_end, w_nxt_end;

    logic          r_byte_vld;
    logic [7:0]    r_byte_dat;
    logic          r_byte_last;

    logic          w_pix_xfer;
    logic          w_load;
    logic [7:0]    w_hdr_byte;
    logic [7:0]    w_byte;
    logic          w_last;
    logic [AW-1:0] w_rd_addr;

    assign w_pix_xfer = pix_valid && r_pix_rdy && (r_state == S_FILL);
    // The output register refills whenever it is empty or being drained this cycle.
    assign w_load     = ((r_state == S_HDR) || (r_state == S_BODY && !r_end)) &&
                        (!r_byte_vld || byte_ready);
    assign w_rd_addr  = AW'(w_nxt_row) * AW'(WIDTH) + AW'(w_nxt_col);

    assign pix_ready  = r_pix_rdy;
    assign byte_valid = r_byte_vld;
    assign byte_data  = r_byte_dat;
    assign byte_last  = r_byte_last;
    assign frame_done = (r_state == S_DONE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_FILL: if (w_pix_xfer && r_pix_cnt == C_PIX_LAST) w_nxt_state = S_HDR;
            S_HDR:  if (w_load && r_hdr_idx == 6'd53) w_nxt_state = S_BODY;
            S_BODY: if (r_byte_vld && byte_ready && r_byte_last) w_nxt_state = S_DONE;
            default: w_nxt_state = S_FILL;
        endcase
    end

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_hdr_idx)
            6'd0:  w_hdr_byte = 8'h42;
            6'd1:  w_hdr_byte = 8'h4D;
            6'd2:  w_hdr_byte = C_FSIZE[7:0];
            6'd3:  w_hdr_byte = C_FSIZE[15:8];
            6'd4:  w_hdr_byte = C_FSIZE[23:16];
            6'd5:  w_hdr_byte = C_FSIZE[31:24];
            6'd10: w_hdr_byte = 8'd54;
            6'd14: w_hdr_byte = 8'd40;
            6'd18: w_hdr_byte = C_W[7:0];
            6'd19: w_hdr_byte = C_W[15:8];
            6'd20: w_hdr_byte = C_W[23:16];
            6'd21: w_hdr_byte = C_W[31:24];
            6'd22: w_hdr_byte = C_H[7:0];
            6'd23: w_hdr_byte = C_H[15:8];
            6'd24: w_hdr_byte = C_H[23:16];
            6'd25: w_hdr_byte = C_H[31:24];
            6'd26: w_hdr_byte = 8'd1;
            6'd28: w_hdr_byte = 8'd24;
            default: w_hdr_byte = 8'h00;
        endcase
    end

    // Byte sequencer: its next position also addresses the store, so pixel data is ready when needed.
    always_comb begin
        logic w_row_end;
        w_nxt_hdr    = r_hdr_idx;
        w_nxt_row    = r_row;
        w_nxt_col    = r_col;
        w_nxt_sub    = r_sub;
        w_nxt_pad    = r_pad;
        w_nxt_in_pad = r_in_pad;
        w_nxt_end    = r_end;
        w_byte       = 8'h00;
        w_last       = 1'b0;
        w_row_end    = 1'b0;
        if (r_state == S_FILL || r_state == S_DONE) begin
            w_nxt_hdr    = 6'd0;
            w_nxt_row    = '0;
            w_nxt_col    = '0;
            w_nxt_sub    = 2'd0;
            w_nxt_pad    = 2'd0;
            w_nxt_in_pad = 1'b0;
            w_nxt_end    = 1'b0;
        end else if (w_load) begin
            if (r_state == S_HDR) begin
                w_byte = w_hdr_byte;
                if (r_hdr_idx == 6'd53) begin
                    w_nxt_row = C_ROW_LAST;
                    w_nxt_col = '0;
                end else begin
                    w_nxt_hdr = r_hdr_idx + 6'd1;
                end
            end else if (r_in_pad) begin
                if (r_pad == C_PAD_LAST) begin
                    w_nxt_in_pad = 1'b0;
                    w_nxt_pad    = 2'd0;
                    w_row_end    = 1'b1;
                end else begin
                    w_nxt_pad = r_pad + 2'd1;
                end
            end else begin
                case (r_sub)
                    2'd0:    w_byte = r_rd_dat[23:16];
                    2'd1:    w_byte = r_rd_dat[15:8];
                    default: w_byte = r_rd_dat[7:0];
                endcase
                if (r_sub != 2'd2) begin
                    w_nxt_sub = r_sub + 2'd1;
                end else begin
                    w_nxt_sub = 2'd0;
                    if (r_col == C_COL_LAST) begin
                        w_nxt_col = '0;
                        if (PAD != 0) w_nxt_in_pad = 1'b1;
                        else          w_row_end    = 1'b1;
                    end else begin
                        w_nxt_col = r_col + CW'(1);
                    end
                end
            end
            if (w_row_end) begin
                if (r_row == '0) begin
                    w_last    = 1'b1;
                    w_nxt_end = 1'b1;
                end else begin
                    w_nxt_row = r_row - RW'(1);
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_pix_xfer) r_store[r_pix_cnt] <= {pix_r, pix_g, pix_b};
        r_rd_dat <= r_store[w_rd_addr];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pix_rdy   <= 1'b0;
            r_pix_cnt   <= '0;
            r_hdr_idx   <= 6'd0;
            r_row       <= '0;
            r_col       <= '0;
            r_sub       <= 2'd0;
            r_pad       <= 2'd0;
            r_in_pad    <= 1'b0;
            r_end       <= 1'b0;
            r_byte_vld  <= 1'b0;
            r_byte_dat  <= 8'h00;
            r_byte_last <= 1'b0;
        end else begin
            r_pix_rdy <= (w_nxt_state == S_FILL);
            if (w_pix_xfer) begin
                r_pix_cnt <= (r_pix_cnt == C_PIX_LAST) ? '0 : r_pix_cnt + AW'(1);
            end
            r_hdr_idx <= w_nxt_hdr;
            r_row     <= w_nxt_row;
            r_col     <= w_nxt_col;
            r_sub     <= w_nxt_sub;
            r_pad     <= w_nxt_pad;
            r_in_pad  <= w_nxt_in_pad;
            r_end     <= w_nxt_end;
            if (w_load) begin
                r_byte_vld  <= 1'b1;
                r_byte_dat  <= w_byte;
                r_byte_last <= w_last;
            end else if (r_byte_vld && byte_ready) begin
                r_byte_vld  <= 1'b0;
                r_byte_last <= 1'b0;
            end
        end
    end

endmodule

// File: doc/image_write.md
IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 Parameter WIDTH, default 8: image width in pixels (1..1024).
REQ-002 Parameter HEIGHT, default 4: image height in pixels (1..1024).
REQ-003 HCLK  input  1  single clock; all state changes on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 pix_valid  input  1  input pixel present.
REQ-006 pix_ready  output  1  block accepts pixel; transfer = pix_valid & pix_ready at a rising edge.
REQ-007 pix_r, pix_g, pix_b  input  8 each  pixel components; raster order, top row first, left to right.
REQ-008 byte_valid  output  1  byte_data holds a valid output byte.
REQ-009 byte_ready  input  1  sink accepts byte; transfer = byte_valid & byte_ready at a rising edge.
REQ-010 byte_data  output  8  BMP file byte stream.
REQ-011 byte_last  output  1  high with the final byte of the file.
REQ-012 frame_done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-013 Internal frame store SHALL hold WIDTH*HEIGHT entries of 24 bits (R,G,B).
REQ-014 FSM states: FILL, HDR, BODY, DONE; reset state FILL.
REQ-015 FILL: pix_ready=1; each transfer writes store[pix_cnt]; pix_cnt increments; on transfer of pixel WIDTH*HEIGHT-1, next state HDR and pix_ready deasserts the following cycle.
REQ-016 HDR: emit 54 header bytes, indices 0..53, little-endian multi-byte fields.
REQ-017 Header content: bytes 0-1 = 0x42,0x4D; 2-5 file size = 54 + HEIGHT*ROWB; 6-9 = 0; 10-13 = 54; 14-17 = 40; 18-21 = WIDTH; 22-25 = HEIGHT; 26-27 = 1; 28-29 = 24; 30-53 = 0.
REQ-018 ROWB = 3*WIDTH rounded up to a multiple of 4; PAD = ROWB - 3*WIDTH (0..3).
REQ-019 BODY: rows emitted bottom-up, row HEIGHT-1 first, row 0 last; within a row, pixels left to right.
REQ-020 Per pixel, 3 bytes in order R, G, B (file offsets +0, +1, +2), matching the team's image reader.
REQ-021 After each row's 3*WIDTH pixel bytes, emit PAD bytes of 0x00.
REQ-022 byte_last=1 only on the final pad byte of row 0, or the B byte of pixel (0,WIDTH-1) if PAD=0.
REQ-023 byte_valid=1 continuously in HDR and BODY; byte_data/byte_last SHALL be held stable while byte_valid & !byte_ready.
REQ-024 Output advances one byte per cycle when byte_ready=1; no bubbles between header and body or between rows.
REQ-025 Store read is registered; first header byte valid no later than 1 cycle after entry to HDR; store latency SHALL never stall a byte_ready=1 sink.
REQ-026 Last byte transfer -> DONE for one cycle: frame_done=1, byte_valid=0, pix_ready=0; then FILL with pix_cnt=0.
REQ-027 pix_valid outside FILL is ignored; pixels are not buffered.
REQ-028 byte_ready with byte_valid=0 has no effect.
REQ-029 Counters sized ceil(log2) of their range; address = row*WIDTH + col, no overflow at WIDTH=HEIGHT=1024.

Reset
REQ-030 HRESETn=0 asynchronously forces: state FILL, all counters 0, pix_ready=0, byte_valid=0, byte_data=0, byte_last=0, frame_done=0.
REQ-031 First rising edge with HRESETn=1 sets pix_ready=1.
REQ-032 Reset mid-frame (any state) discards partial input/output; store contents need not be cleared.

Verification
REQ-033 WIDTH=8,HEIGHT=4, pixel k = (k, k+0x40, k+0x80), byte_ready=1 -> 54 header bytes with size field 150 (0x96,0,0,0), then bytes 0x18,0x58,0x98 first (pixel 24), byte_last with 0x87 (pixel 7 B), 150 bytes total, frame_done 1 cycle later.
REQ-034 WIDTH=5,HEIGHT=2 -> ROWB=16, file size 86; one 0x00 pad after each 15-byte row; byte_last on byte index 85 = 0x00.
REQ-035 Random byte_ready (50%) -> byte stream identical to REQ-033; byte_data held on every stalled cycle.
REQ-036 Random pix_valid gaps -> exactly 32 pixel transfers accepted; pix_ready=0 from cycle after 32nd transfer until DONE exits.
REQ-037 HRESETn pulsed low during BODY at byte 100 -> byte_valid=0 immediately; new 32-pixel frame afterwards produces a correct full 150-byte file.
REQ-038 Two back-to-back frames -> second file correct, header repeated, no carried-over state.
